// File: rtl/regfile_writeback.sv
// Result writeback queue: collects completions from ALU/MUL/MEM producers and
// drains up to two entries per cycle onto the register file's two write ports.

module regfile_writeback_lane #(
    parameter int CW = 3,
    parameter int PW = 2
) (
    input  logic          enable,
    input  logic          valid,
    input  logic [CW-1:0] free,
    input  logic [CW-1:0] prefix,
    input  logic [PW-1:0] tail,
    output logic          ready,
    output logic          accept,
    output logic [PW-1:0] slot
);
    logic [CW:0] need;

    // Ready is monotone in source order, so an accepted lane's queue offset
    // equals the number of valids ahead of it.
    assign need   = {1'b0, prefix} + (CW+1)'(valid);
    assign ready  = enable && ({1'b0, free} >= need);
    assign accept = ready && valid;
    assign slot   = tail + PW'(prefix);
endmodule

module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int NSRC  = 3,
    parameter int XLEN  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NSRC-1:0]           in_valid,
    input  logic [NSRC-1:0][4:0]      in_idx,
    input  logic [NSRC-1:0][XLEN-1:0] in_data,
    output logic [NSRC-1:0]           in_ready,
    output logic                      write_en_1,
    output logic [4:0]                write_idx_1,
    output logic [XLEN-1:0]           write_data_1,
    output logic                      write_en_2,
    output logic [4:0]                write_idx_2,
    output logic [XLEN-1:0]           write_data_2,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]      idx;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   free, pushes, pops;
    logic [CW-1:0]   prefix [NSRC];
    logic [PW-1:0]   slot [NSRC];
    logic [NSRC-1:0] accept;
    entry_t          e1, e2;

    // Pops freed this cycle are deliberately not credited to free space.
    assign free = CW'(DEPTH) - count;
    assign pops = (count >= CW'(2)) ? CW'(2) : count;

    always_comb begin
        logic [CW-1:0] run;
        run = '0;
        for (int i = 0; i < NSRC; i++) begin
            prefix[i] = run;
            run       = run + CW'(in_valid[i]);
        end
    end

    always_comb begin
        pushes = '0;
        for (int i = 0; i < NSRC; i++)
            pushes = pushes + CW'(accept[i]);
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_lane
        regfile_writeback_lane #(.CW(CW), .PW(PW)) u_lane (
            .enable (!reset),
            .valid  (in_valid[g]),
            .free   (free),
            .prefix (prefix[g]),
            .tail   (tail),
            .ready  (in_ready[g]),
            .accept (accept[g]),
            .slot   (slot[g])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pops);
            tail  <= tail + PW'(pushes);
            count <= count + pushes - pops;
        end
    end

    // Storage needs no reset: nothing is presented unless count covers it.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NSRC; i++)
            if (accept[i])
                mem[slot[i]] <= '{idx: in_idx[i], data: in_data[i]};
    end

    assign e1 = mem[head];
    assign e2 = mem[head + PW'(1)];

    assign write_en_1   = (count >= CW'(1)) && (e1.idx != 5'd0);
    assign write_idx_1  = (count >= CW'(1)) ? e1.idx  : '0;
    assign write_data_1 = (count >= CW'(1)) ? e1.data : '0;
    assign write_en_2   = (count >= CW'(2)) && (e2.idx != 5'd0);
    assign write_idx_2  = (count >= CW'(2)) ? e2.idx  : '0;
    assign write_data_2 = (count >= CW'(2)) ? e2.data : '0;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes go into a queue at issue
// time and a negedge monitor pops them as the write ports present entries.

module tb_regfile_writeback;
    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       in_valid;
    logic [2:0][4:0]  in_idx;
    logic [2:0][31:0] in_data;
    logic [2:0]       in_ready;
    logic             write_en_1, write_en_2;
    logic [4:0]       write_idx_1, write_idx_2;
    logic [31:0]      write_data_1, write_data_2;
    logic [2:0]       count;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, failures = 0, model_cnt = 0;
    bit          mon_en = 1'b0;
    logic [31:0] rf [32];

    regfile_writeback #(.DEPTH(4), .NSRC(3), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_idx(in_idx), .in_data(in_data), .in_ready(in_ready),
        .write_en_1(write_en_1), .write_idx_1(write_idx_1), .write_data_1(write_data_1),
        .write_en_2(write_en_2), .write_idx_2(write_idx_2), .write_data_2(write_data_2),
        .count(count)
    );

    always #5 clock = ~clock;

    // Register file model: port 2 lands last, so it wins on a shared index.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (write_en_1) rf[write_idx_1] <= write_data_1;
            if (write_en_2) rf[write_idx_2] <= write_data_2;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic port_chk(input string p, input logic en, input logic [4:0] idx,
                            input logic [31:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected actual=idx%0d required=no_entry", p, idx);
        end else begin
            e = exp_q.pop_front();
            chk({p, "_idx"}, 64'(idx), 64'(e.idx));
            chk({p, "_data"}, 64'(data), 64'(e.data));
            chk({p, "_en"}, 64'(en), 64'(e.idx != 5'd0));
        end
    endtask

    always @(negedge clock) begin
        if (mon_en && !reset) begin
            chk("count", 64'(count), 64'(model_cnt));
            if (count >= 3'd1) port_chk("port1", write_en_1, write_idx_1, write_data_1);
            else chk("port1_idle", {write_en_1, write_idx_1, write_data_1}, 64'd0);
            if (count >= 3'd2) port_chk("port2", write_en_2, write_idx_2, write_data_2);
            else chk("port2_idle", {write_en_2, write_idx_2, write_data_2}, 64'd0);
        end
    end

    // Called at posedge+1; returns at the following posedge+1.
    task automatic drive(input logic [2:0] v, input logic [2:0][4:0] idx,
                         input logic [2:0][31:0] dat, input logic [2:0] exp_rdy);
        int pcnt;
        int pops;
        pcnt = 0;
        in_valid = v;
        in_idx   = idx;
        in_data  = dat;
        #1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        for (int i = 0; i < 3; i++)
            if (v[i] && exp_rdy[i]) begin
                exp_q.push_back('{idx: idx[i], data: dat[i]});
                pcnt++;
            end
        @(posedge clock);
        pops = (model_cnt >= 2) ? 2 : model_cnt;
        model_cnt = model_cnt + pcnt - pops;
        #1;
        in_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(3'b000, '0, '0, 3'b111);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]       bp_rdy [6];
        logic [2:0][4:0]  bi;
        logic [2:0][31:0] bd;
        bp_rdy = '{3'b111, 3'b001, 3'b011, 3'b011, 3'b011, 3'b011};

        in_valid = 3'b111;
        in_idx   = '0;
        in_data  = '0;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_port1", {write_en_1, write_idx_1, write_data_1}, 64'd0);
        chk("rst_port2", {write_en_2, write_idx_2, write_data_2}, 64'd0);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = '0;
        mon_en   = 1'b1;

        // single push
        drive(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF}, 3'b111);
        idle(2);
        // triple push into empty queue
        drive(3'b111, {5'd12, 5'd11, 5'd10}, {32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A}, 3'b111);
        idle(3);
        // same-index ordering
        drive(3'b011, {5'd0, 5'd20, 5'd20}, {32'd0, 32'h22222222, 32'h11111111}, 3'b111);
        idle(2);
        chk("rf_x20", 64'(rf[20]), 64'h22222222);
        // zero register
        drive(3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFFFFFF, 32'd0, 32'd0}, 3'b111);
        idle(2);
        chk("rf_x0", 64'(rf[0]), 64'd0);

        // sustained backpressure
        for (int c = 0; c < 6; c++) begin
            for (int s = 0; s < 3; s++) begin
                bi[s] = 5'(1 + c * 3 + s);
                bd[s] = 32'hB0000000 + 32'(c * 16 + s);
            end
            drive(3'b111, bi, bd, bp_rdy[c]);
        end
        idle(4);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // reset mid-stream with three entries queued
        drive(3'b111, {5'd27, 5'd26, 5'd25}, {32'h27272727, 32'h26262626, 32'h25252525}, 3'b111);
        reset     = 1'b1;
        model_cnt = 0;
        exp_q.delete();
        in_valid  = 3'b111;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_we", 64'({write_en_1, write_en_2}), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        in_valid = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(3);
        chk("post_rst_rf", 64'({rf[25] | rf[26] | rf[27]}), 64'd0);
        chk("post_rst_queue", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
